battle_phase_fsm: RTL and testbench
===================================

Name: battle_phase_fsm

Overview:
- Parametrised turn-based battle controller that generalises the game phase machine.
- Sequences MENU -> DODGE -> ACTION -> ATTACK, plus terminal WIN and LOSE pages.
- Emits 16-bit player instructions to the player/HP block and tracks monster HP with saturating subtraction.
- Sits between the key converter (4-bit key codes) and the player, bullet and attack-bar blocks; timing comes from a one-cycle tick enable in the single clock domain.

Parameters:
- DODGE_TICKS, 7, number of ticks spent in DODGE before entering ACTION (range 1..15)
- ATK_TICKS, 5, ticks allowed in ATTACK without atk_pass before a miss (range 1..15)
- HP_W, 8, width of monster HP and of damage inputs
- MON_HP_MAX, 100, monster HP loaded when a game starts (must be below 2^HP_W)
- HEAL_AMT, 10, heal amount placed in the HPY instruction argument (8 bits)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timing enable (nominal 1 Hz), synchronous to clk
- key  in  4  converted key code: 0=none, 1=W, 2=A, 3=S, 4=D, 5=J, 6=K, 7=L, 8=SPACE
- player_dead  in  1  player HP reached zero
- dmg_event  in  1  one-cycle pulse: a bullet collision is resolved
- heal  in  1  qualifies dmg_event as a heal pickup
- damage  in  8  damage amount for dmg_event
- atk_pass  in  1  one-cycle pulse: attack bar has been stopped
- dmg_mon  in  HP_W  damage to apply to the monster on atk_pass
- state  out  8  {page[3:0], substate[3:0]}
- player_instr  out  16  {op[3:0], arg[7:0], 4'b0}
- move_valid  out  1  player_instr holds a valid MOV this cycle
- start_dmg  out  1  one-cycle pulse: player_instr holds HPY or DPY
- mon_hp  out  HP_W  remaining monster HP

Behaviour:
- Page codes: MENU=1, WIN=2, LOSE=3, DODGE=9, ATTACK=10, ACTION=11.
- Opcodes: HPY=1, DPY=2, MOV=5. MOV args: UP=0, LEFT=1, DOWN=2, RIGHT=3.
- All outputs are registered.
- Reset (asynchronous, active while rst_n=0) sets: state={MENU,0}, player_instr=0, move_valid=0, start_dmg=0, mon_hp=MON_HP_MAX, key_prev=0.
- move_valid and start_dmg default to 0 in every cycle unless set by a rule below.
- A key "press" means key!=0 and key!=key_prev. key_prev is registered every cycle.
- MENU:
  - SPACE press -> {DODGE,0}, mon_hp=MON_HP_MAX, player_instr=0.
- DODGE: substate counts ticks. Priority per cycle, highest first:
  - player_dead=1 -> {LOSE,0}.
  - tick=1 with substate==DODGE_TICKS-1 -> {ACTION,0}, player_instr=0.
  - tick=1 otherwise -> substate+1.
  - dmg_event=1 -> player_instr={HPY,HEAL_AMT,0} if heal, else {DPY,damage,0}; start_dmg=1.
  - Otherwise movement, level-sensitive: W/A/S/D -> MOV with UP/LEFT/DOWN/RIGHT, move_valid=1. Any other key -> player_instr=0.
  - Movement is evaluated in the same cycle as a non-final tick increment. A dmg_event coinciding with the final tick is dropped.
- ACTION: substate is the menu cursor, 0=FIGHT, 1=HEAL, 2=FLEE.
  - A press: cursor-1, wrapping 0->2.
  - D press: cursor+1, wrapping 2->0.
  - J press on FIGHT -> {ATTACK,0}.
  - J press on HEAL -> player_instr={HPY,HEAL_AMT,0}, start_dmg=1, then {DODGE,0}.
  - J press on FLEE -> {MENU,0}.
  - All other keys and tick are ignored. A held key moves the cursor once.
- ATTACK: substate counts ticks.
  - atk_pass=1 -> mon_hp = mon_hp - dmg_mon, saturating at 0 (never wraps). Next state is {WIN,0} if the result is 0, else {DODGE,0}.
  - Otherwise tick with substate==ATK_TICKS-1 -> miss, {DODGE,0}, mon_hp unchanged.
  - Otherwise tick -> substate+1.
  - atk_pass wins over a simultaneous final tick.
- WIN/LOSE:
  - SPACE press -> {MENU,0}.
  - Inputs other than key are ignored.
- Undefined page (unreachable) -> {MENU,0} on the next clock.
- Every page transition clears substate.
- rst_n low mid-operation aborts immediately to reset values. A pending start_dmg is lost.

Test Plan:
- Reset, then key=8 for 1 cycle -> state=0x90, mon_hp=100, player_instr=0.
- In DODGE, key=1 held 3 cycles -> player_instr=0x5000 and move_valid=1 each cycle. Key=3 -> 0x5020.
- In DODGE, dmg_event with damage=0x0C, heal=0 -> player_instr=0x20C0, start_dmg high exactly 1 cycle. With heal=1 -> 0x10A0.
- In DODGE, 7 ticks -> state steps 0x90..0x96, then 0xB0. player_dead during DODGE -> 0x30 on the next clock, even with tick high.
- In ACTION, D held 10 cycles -> cursor 1 only. A press from cursor 0 -> cursor 2. J on cursor 1 -> HPY pulse, then 0x90.
- In ATTACK with mon_hp=30: atk_pass with dmg_mon=45 -> mon_hp=0, state=0x20. With dmg_mon=10 -> mon_hp=20, state=0x90. No atk_pass for 5 ticks -> 0x90, mon_hp unchanged.

Source files
------------

// File: rtl/battle_phase_fsm.sv
// battle_phase_fsm: turn-based battle sequencer (menu, dodge, action, attack, win/lose) driving player instructions and monster HP.
module battle_phase_fsm #(
   parameter int DODGE_TICKS = 7,
   parameter int ATK_TICKS   = 5,
   parameter int HP_W        = 8,
   parameter int MON_HP_MAX  = 100,
   parameter int HEAL_AMT    = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tick,
   input  logic [3:0]      key,
   input  logic            player_dead,
   input  logic            dmg_event,
   input  logic            heal,
   input  logic [7:0]      damage,
   input  logic            atk_pass,
   input  logic [HP_W-1:0] dmg_mon,
   output logic [7:0]      state,
   output logic [15:0]     player_instr,
   output logic            move_valid,
   output logic            start_dmg,
   output logic [HP_W-1:0] mon_hp
);
   typedef enum logic [3:0] {
      MENU   = 4'd1,
      WIN    = 4'd2,
      LOSE   = 4'd3,
      DODGE  = 4'd9,
      ATTACK = 4'd10,
      ACTION = 4'd11
   } page_t;

   localparam logic [3:0]  K_W = 4'd1;
   localparam logic [3:0]  K_A = 4'd2;
   localparam logic [3:0]  K_D = 4'd4;
   localparam logic [3:0]  K_J = 4'd5;
   localparam logic [3:0]  K_SP = 4'd8;
   localparam logic [3:0]  DODGE_LAST = 4'(DODGE_TICKS - 1);
   localparam logic [3:0]  ATK_LAST = 4'(ATK_TICKS - 1);
   localparam logic [15:0] I_HPY = {4'd1, 8'(HEAL_AMT), 4'd0};

   page_t           page;
   logic [3:0]      sub;
   logic [3:0]      key_prev;
   logic            press;
   logic [HP_W-1:0] hp_left;

   assign state   = {page, sub};
   assign press   = key != 4'd0 && key != key_prev;
   assign hp_left = mon_hp > dmg_mon ? mon_hp - dmg_mon : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         page         <= MENU;
         sub          <= 4'd0;
         player_instr <= 16'd0;
         move_valid   <= 1'b0;
         start_dmg    <= 1'b0;
         mon_hp       <= HP_W'(MON_HP_MAX);
         key_prev     <= 4'd0;
      end else begin
         key_prev   <= key;
         move_valid <= 1'b0;
         start_dmg  <= 1'b0;
         case (page)
            MENU:
               if (press && key == K_SP) begin
                  page         <= DODGE;
                  sub          <= 4'd0;
                  mon_hp       <= HP_W'(MON_HP_MAX);
                  player_instr <= 16'd0;
               end
            DODGE:
               if (player_dead) begin
                  page <= LOSE;
                  sub  <= 4'd0;
               end else if (tick && sub == DODGE_LAST) begin
                  page         <= ACTION;
                  sub          <= 4'd0;
                  player_instr <= 16'd0;
               end else begin
                  if (tick) sub <= sub + 4'd1;
                  if (dmg_event) begin
                     player_instr <= heal ? I_HPY : {4'd2, damage, 4'd0};
                     start_dmg    <= 1'b1;
                  end else if (key >= K_W && key <= K_D) begin
                     player_instr <= {4'd5, 4'd0, key - K_W, 4'd0};
                     move_valid   <= 1'b1;
                  end else begin
                     player_instr <= 16'd0;
                  end
               end
            ACTION:
               if (press) begin
                  if (key == K_A) begin
                     sub <= sub == 4'd0 ? 4'd2 : sub - 4'd1;
                  end else if (key == K_D) begin
                     sub <= sub == 4'd2 ? 4'd0 : sub + 4'd1;
                  end else if (key == K_J && sub == 4'd0) begin
                     page <= ATTACK;
                     sub  <= 4'd0;
                  end else if (key == K_J && sub == 4'd1) begin
                     player_instr <= I_HPY;
                     start_dmg    <= 1'b1;
                     page         <= DODGE;
                     sub          <= 4'd0;
                  end else if (key == K_J && sub == 4'd2) begin
                     page <= MENU;
                     sub  <= 4'd0;
                  end
               end
            ATTACK:
               if (atk_pass) begin
                  mon_hp <= hp_left;
                  page   <= hp_left == '0 ? WIN : DODGE;
                  sub    <= 4'd0;
               end else if (tick && sub == ATK_LAST) begin
                  page <= DODGE;
                  sub  <= 4'd0;
               end else if (tick) begin
                  sub <= sub + 4'd1;
               end
            WIN, LOSE:
               if (press && key == K_SP) begin
                  page <= MENU;
                  sub  <= 4'd0;
               end
            default: begin
               page <= MENU;
               sub  <= 4'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_battle_phase_fsm.sv
// tb_battle_phase_fsm: directed vectors with hand-computed expectations for battle_phase_fsm.
module tb_battle_phase_fsm;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic [3:0]  key = 4'd0;
   logic        player_dead = 1'b0;
   logic        dmg_event = 1'b0;
   logic        heal = 1'b0;
   logic [7:0]  damage = 8'd0;
   logic        atk_pass = 1'b0;
   logic [7:0]  dmg_mon = 8'd0;
   logic [7:0]  state;
   logic [15:0] player_instr;
   logic        move_valid;
   logic        start_dmg;
   logic [7:0]  mon_hp;
   int          checks = 0;
   int          failures = 0;

   battle_phase_fsm dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .key(key), .player_dead(player_dead),
      .dmg_event(dmg_event), .heal(heal), .damage(damage), .atk_pass(atk_pass),
      .dmg_mon(dmg_mon), .state(state), .player_instr(player_instr),
      .move_valid(move_valid), .start_dmg(start_dmg), .mon_hp(mon_hp)
   );

   always #5 clk = ~clk;

   task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task cyc();
      @(posedge clk);
      #1;
   endtask

   task ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
      end
   endtask

   task press(input logic [3:0] k);
      key = k;
      cyc();
      key = 4'd0;
      cyc();
   endtask

   task to_attack();
      ticks(7);
      check("to_action", state, 8'hB0);
      press(4'd5);
      check("to_attack", state, 8'hA0);
   endtask

   task hit(input logic [7:0] d);
      atk_pass = 1'b1;
      dmg_mon = d;
      cyc();
      atk_pass = 1'b0;
   endtask

   initial begin
      repeat (2) cyc();
      check("rst_state", state, 8'h10);
      check("rst_instr", player_instr, 16'h0);
      check("rst_mv", move_valid, 1'b0);
      check("rst_sd", start_dmg, 1'b0);
      check("rst_hp", mon_hp, 8'd100);
      rst_n = 1'b1;
      cyc();
      check("menu_idle", state, 8'h10);
      key = 4'd8;
      cyc();
      key = 4'd0;
      check("start_state", state, 8'h90);
      check("start_hp", mon_hp, 8'd100);
      check("start_instr", player_instr, 16'h0);
      key = 4'd1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("mov_up", player_instr, 16'h5000);
         check("mov_up_valid", move_valid, 1'b1);
      end
      key = 4'd3;
      cyc();
      check("mov_down", player_instr, 16'h5020);
      key = 4'd4;
      cyc();
      check("mov_right", player_instr, 16'h5030);
      key = 4'd0;
      cyc();
      check("mov_none", player_instr, 16'h0);
      check("mov_none_valid", move_valid, 1'b0);
      dmg_event = 1'b1;
      damage = 8'h0C;
      cyc();
      dmg_event = 1'b0;
      check("dpy_instr", player_instr, 16'h20C0);
      check("dpy_sd", start_dmg, 1'b1);
      cyc();
      check("dpy_sd_once", start_dmg, 1'b0);
      dmg_event = 1'b1;
      heal = 1'b1;
      cyc();
      dmg_event = 1'b0;
      heal = 1'b0;
      check("hpy_instr", player_instr, 16'h10A0);
      check("hpy_sd", start_dmg, 1'b1);
      cyc();
      check("hpy_sd_once", start_dmg, 1'b0);
      for (int i = 1; i < 7; i++) begin
         ticks(1);
         check("dodge_step", state, 8'h90 + 8'(i));
      end
      ticks(1);
      check("dodge_done", state, 8'hB0);
      key = 4'd4;
      repeat (10) cyc();
      check("cursor_held", state, 8'hB1);
      key = 4'd0;
      cyc();
      press(4'd2);
      check("cursor_a", state, 8'hB0);
      press(4'd2);
      check("cursor_wrap_a", state, 8'hB2);
      press(4'd4);
      check("cursor_wrap_d", state, 8'hB0);
      press(4'd4);
      key = 4'd5;
      cyc();
      key = 4'd0;
      check("heal_state", state, 8'h90);
      check("heal_instr", player_instr, 16'h10A0);
      check("heal_sd", start_dmg, 1'b1);
      cyc();
      check("heal_sd_once", start_dmg, 1'b0);
      player_dead = 1'b1;
      tick = 1'b1;
      cyc();
      player_dead = 1'b0;
      tick = 1'b0;
      check("dead", state, 8'h30);
      ticks(3);
      check("lose_hold", state, 8'h30);
      press(4'd8);
      check("lose_menu", state, 8'h10);
      press(4'd8);
      check("restart", state, 8'h90);
      to_attack();
      hit(8'd70);
      check("hp_70", mon_hp, 8'd30);
      check("hit_dodge", state, 8'h90);
      to_attack();
      hit(8'd10);
      check("hp_10", mon_hp, 8'd20);
      check("hit2_dodge", state, 8'h90);
      to_attack();
      ticks(4);
      check("atk_count", state, 8'hA4);
      ticks(1);
      check("miss_state", state, 8'h90);
      check("miss_hp", mon_hp, 8'd20);
      to_attack();
      ticks(4);
      tick = 1'b1;
      hit(8'd45);
      tick = 1'b0;
      check("sat_hp", mon_hp, 8'd0);
      check("win", state, 8'h20);
      press(4'd8);
      check("win_menu", state, 8'h10);
      press(4'd8);
      check("reload_hp", mon_hp, 8'd100);
      dmg_event = 1'b1;
      cyc();
      dmg_event = 1'b0;
      check("pre_rst_sd", start_dmg, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_sd", start_dmg, 1'b0);
      check("async_state", state, 8'h10);
      check("async_instr", player_instr, 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
